// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode encodings
// and a helper that tells which modes may run as a multi-cycle burst.
package usr_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_HOLD = 3'd0;
    localparam logic [MODE_W-1:0] MODE_SHL  = 3'd1;
    localparam logic [MODE_W-1:0] MODE_SHR  = 3'd2;
    localparam logic [MODE_W-1:0] MODE_ASR  = 3'd3;
    localparam logic [MODE_W-1:0] MODE_ROL  = 3'd4;
    localparam logic [MODE_W-1:0] MODE_ROR  = 3'd5;
    localparam logic [MODE_W-1:0] MODE_LOAD = 3'd6;
    localparam logic [MODE_W-1:0] MODE_CLR  = 3'd7;

    // Only shifts and rotates can be repeated by the burst engine.
    function automatic logic is_shift_mode(input logic [MODE_W-1:0] m);
        return (m >= MODE_SHL) && (m <= MODE_ROR);
    endfunction

endpackage

// File: rtl/usr_next_val.sv
// Combinational next-value logic for the shift register. One instance
// serves both single-cycle operations and burst steps; the caller picks
// which mode to feed in.
module usr_next_val
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]  q,
    input  logic [MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]  d,
    input  logic              sin_l,
    input  logic              sin_r,
    output logic [WIDTH-1:0]  q_next
);

    // Select the next register value for the requested operation.
    always_comb begin
        q_next = q;
        case (mode)
            MODE_HOLD: q_next = q;
            MODE_SHL:  q_next = {q[WIDTH-2:0], sin_l};
            MODE_SHR:  q_next = {sin_r, q[WIDTH-1:1]};
            MODE_ASR:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
            MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
            MODE_LOAD: q_next = d;
            MODE_CLR:  q_next = '0;
            default:   q_next = q;
        endcase
    end

endmodule

// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal shift register with clock enable, per-cycle mode
// select and a burst engine that repeats one shift/rotate N times.
// Optional build macro USR_PARITY_EN adds a registered even-parity output
// that always matches ^q.
//
// Burst control: burst_start is taken only while idle with en=1 and a
// shift/rotate mode. The first operation happens on the accepting edge;
// cnt_q then holds the operations still outstanding. busy is high while
// cnt_q is nonzero; done pulses for one cycle after the final operation.
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [2:0]        mode,
    input  logic [WIDTH-1:0]  d,
    input  logic              sin_l,
    input  logic              sin_r,
    input  logic              burst_start,
    input  logic [CNT_W-1:0]  burst_len,
    output logic [WIDTH-1:0]  q,
    output logic              sout_l,
    output logic              sout_r,
    output logic              busy,
`ifdef USR_PARITY_EN
    output logic              parity,
`endif
    output logic              done
);

    logic [WIDTH-1:0]  q_q, q_d, q_next;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [MODE_W-1:0] op_mode;

    // During a burst the latched mode drives the datapath, else the live input.
    assign op_mode = busy_q ? mode_q : mode;

    usr_next_val #(
        .WIDTH (WIDTH)
    ) u_next_val (
        .q      (q_q),
        .mode   (op_mode),
        .d      (d),
        .sin_l  (sin_l),
        .sin_r  (sin_r),
        .q_next (q_next)
    );

    // Next-state logic for the register and the burst controller.
    always_comb begin
        q_d    = q_q;
        cnt_d  = cnt_q;
        mode_d = mode_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (en) begin
            if (busy_q) begin
                q_d = q_next;
                if (cnt_q == CNT_W'(1)) begin
                    cnt_d  = '0;
                    busy_d = 1'b0;
                    mode_d = MODE_HOLD;
                    done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end else if (burst_start && is_shift_mode(mode)) begin
                if (burst_len == '0) begin
                    done_d = 1'b1;
                end else begin
                    q_d = q_next;
                    if (burst_len == CNT_W'(1)) begin
                        done_d = 1'b1;
                    end else begin
                        cnt_d  = burst_len - CNT_W'(1);
                        busy_d = 1'b1;
                        mode_d = mode;
                    end
                end
            end else begin
                q_d = q_next;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q_q    <= '0;
            cnt_q  <= '0;
            mode_q <= MODE_HOLD;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

`ifdef USR_PARITY_EN
    logic parity_q;

    // Parity of the value being loaded, so it lines up with q in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ^q_d;
        end
    end

    assign parity = parity_q;
`endif

    assign q      = q_q;
    assign sout_l = q_q[WIDTH-1];
    assign sout_r = q_q[0];
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Testbench for universal_shift_reg (WIDTH=8, CNT_W=4): a vector table for
// single-cycle modes and a short burst, plus hand-written multi-cycle
// sequences for pause, zero/max length and reset abort.
module tb_universal_shift_reg;
    import usr_pkg::*;

    localparam int W = 8;
    localparam int C = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [2:0]   mode;
    logic [W-1:0] d;
    logic         sin_l;
    logic         sin_r;
    logic         burst_start;
    logic [C-1:0] burst_len;
    logic [W-1:0] q;
    logic         sout_l;
    logic         sout_r;
    logic         busy;
    logic         done;

    int total = 0;
    int bad   = 0;

    universal_shift_reg #(.WIDTH(W), .CNT_W(C)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .mode        (mode),
        .d           (d),
        .sin_l       (sin_l),
        .sin_r       (sin_r),
        .burst_start (burst_start),
        .burst_len   (burst_len),
        .q           (q),
        .sout_l      (sout_l),
        .sout_r      (sout_r),
        .busy        (busy),
        .done        (done)
    );

    // Clock.
    always #5 clk = ~clk;

    // Vector record: inputs applied before an edge, outputs expected after it.
    typedef struct {
        string        name;
        logic         rst;
        logic         en;
        logic [2:0]   mode;
        logic [W-1:0] d;
        logic         sl;
        logic         sr;
        logic         bs;
        logic [C-1:0] len;
        logic [W-1:0] eq;
        logic         eb;
        logic         ed;
    } vec_t;

    vec_t vq[$];

    task automatic add(input string name, input logic r, input logic e,
                       input logic [2:0] m, input logic [W-1:0] dd,
                       input logic sl, input logic sr, input logic bs,
                       input logic [C-1:0] len, input logic [W-1:0] eq,
                       input logic eb, input logic ed);
        vec_t v;
        v.name = name; v.rst = r; v.en = e; v.mode = m; v.d = dd;
        v.sl = sl; v.sr = sr; v.bs = bs; v.len = len;
        v.eq = eq; v.eb = eb; v.ed = ed;
        vq.push_back(v);
    endtask

    task automatic drive(input logic r, input logic e, input logic [2:0] m,
                         input logic [W-1:0] dd, input logic sl, input logic sr,
                         input logic bs, input logic [C-1:0] len);
        rst = r; en = e; mode = m; d = dd;
        sin_l = sl; sin_r = sr; burst_start = bs; burst_len = len;
    endtask

    // Advance one edge and sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [W-1:0] eq,
                       input logic eb, input logic ed);
        total++;
        if (q !== eq || busy !== eb || done !== ed ||
            sout_l !== eq[W-1] || sout_r !== eq[0]) begin
            bad++;
            $display("FAIL %s: q=%h busy=%b done=%b sout_l=%b sout_r=%b, required q=%h busy=%b done=%b",
                     name, q, busy, done, sout_l, sout_r, eq, eb, ed);
        end
    endtask

    initial begin
        int done_cnt;
        logic [W-1:0] exp_v;

        drive(1'b0, 1'b1, MODE_LOAD, 8'hFF, 1'b0, 1'b0, 1'b0, 4'd0);
        step();
        chk("reset_initial", 8'h00, 1'b0, 1'b0);

        // Reset is synchronous: q keeps its value until the edge.
        drive(1'b1, 1'b1, MODE_LOAD, 8'h5A, 1'b0, 1'b0, 1'b0, 4'd0);
        step();
        chk("load_5a", 8'h5A, 1'b0, 1'b0);
        drive(1'b0, 1'b1, MODE_LOAD, 8'hFF, 1'b0, 1'b0, 1'b0, 4'd0);
        #1;
        chk("reset_before_edge", 8'h5A, 1'b0, 1'b0);
        step();
        chk("reset_after_edge", 8'h00, 1'b0, 1'b0);

        // Table: single-cycle modes, en gating, a short burst, non-burst starts.
        add("load_a5",   1, 1, MODE_LOAD, 8'hA5, 0, 0, 0, 0, 8'hA5, 0, 0);
        add("shl_1",     1, 1, MODE_SHL,  8'h00, 1, 0, 0, 0, 8'h4B, 0, 0);
        add("shr_0",     1, 1, MODE_SHR,  8'h00, 0, 0, 0, 0, 8'h25, 0, 0);
        add("load_80",   1, 1, MODE_LOAD, 8'h80, 0, 0, 0, 0, 8'h80, 0, 0);
        add("asr",       1, 1, MODE_ASR,  8'h00, 0, 0, 0, 0, 8'hC0, 0, 0);
        add("load_81",   1, 1, MODE_LOAD, 8'h81, 0, 0, 0, 0, 8'h81, 0, 0);
        add("rol",       1, 1, MODE_ROL,  8'h00, 0, 0, 0, 0, 8'h03, 0, 0);
        add("ror",       1, 1, MODE_ROR,  8'h00, 0, 0, 0, 0, 8'h81, 0, 0);
        add("hold",      1, 1, MODE_HOLD, 8'h33, 1, 1, 0, 0, 8'h81, 0, 0);
        add("clr",       1, 1, MODE_CLR,  8'h33, 0, 0, 0, 0, 8'h00, 0, 0);
        add("en_low",    1, 0, MODE_LOAD, 8'hFF, 0, 0, 0, 0, 8'h00, 0, 0);
        add("shr_1",     1, 1, MODE_SHR,  8'h00, 0, 1, 0, 0, 8'h80, 0, 0);
        add("shl_0",     1, 1, MODE_SHL,  8'h00, 0, 1, 0, 0, 8'h00, 0, 0);
        add("load_01",   1, 1, MODE_LOAD, 8'h01, 0, 0, 0, 0, 8'h01, 0, 0);
        add("brst_op1",  1, 1, MODE_ROL,  8'h00, 0, 0, 1, 3, 8'h02, 1, 0);
        add("brst_op2",  1, 1, MODE_HOLD, 8'h00, 0, 0, 0, 0, 8'h04, 1, 0);
        add("brst_op3",  1, 1, MODE_HOLD, 8'h00, 0, 0, 0, 0, 8'h08, 0, 1);
        add("brst_after",1, 1, MODE_HOLD, 8'h00, 0, 0, 0, 0, 8'h08, 0, 0);
        add("bs_load",   1, 1, MODE_LOAD, 8'h3C, 0, 0, 1, 5, 8'h3C, 0, 0);
        add("bs_load_h", 1, 1, MODE_HOLD, 8'h00, 0, 0, 0, 0, 8'h3C, 0, 0);
        add("bs_en_low", 1, 0, MODE_ROL,  8'h00, 0, 0, 1, 2, 8'h3C, 0, 0);
        add("bs_no_q",   1, 1, MODE_HOLD, 8'h00, 0, 0, 0, 0, 8'h3C, 0, 0);
        add("len1",      1, 1, MODE_SHL,  8'h00, 1, 0, 1, 1, 8'h79, 0, 1);
        add("len1_h",    1, 1, MODE_HOLD, 8'h00, 0, 0, 0, 0, 8'h79, 0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst, vq[i].en, vq[i].mode, vq[i].d,
                  vq[i].sl, vq[i].sr, vq[i].bs, vq[i].len);
            step();
            chk(vq[i].name, vq[i].eq, vq[i].eb, vq[i].ed);
        end

        // Pause and ignore: ROR x4 on 10, en low twice, LOAD FF offered while busy.
        drive(1, 1, MODE_LOAD, 8'h10, 0, 0, 0, 0);
        step(); chk("p_load", 8'h10, 0, 0);
        drive(1, 1, MODE_ROR, 8'h00, 0, 0, 1, 4);
        step(); chk("p_op1", 8'h08, 1, 0);
        drive(1, 0, MODE_LOAD, 8'hFF, 1, 1, 1, 7);
        step(); chk("p_pause1", 8'h08, 1, 0);
        step(); chk("p_pause2", 8'h08, 1, 0);
        en = 1'b1;
        step(); chk("p_op2", 8'h04, 1, 0);
        step(); chk("p_op3", 8'h02, 1, 0);
        step(); chk("p_op4", 8'h01, 0, 1);
        drive(1, 1, MODE_HOLD, 8'h00, 0, 0, 0, 0);
        step(); chk("p_after", 8'h01, 0, 0);

        // Zero-length burst: q holds, done next cycle, never busy.
        drive(1, 1, MODE_SHL, 8'h00, 1, 0, 1, 0);
        step(); chk("len0", 8'h01, 0, 1);
        drive(1, 1, MODE_HOLD, 8'h00, 0, 0, 0, 0);
        step(); chk("len0_after", 8'h01, 0, 0);

        // Maximum burst: 15 x SHL with sin_l=0 on FF.
        drive(1, 1, MODE_LOAD, 8'hFF, 0, 0, 0, 0);
        step(); chk("m_load", 8'hFF, 0, 0);
        drive(1, 1, MODE_SHL, 8'h00, 0, 0, 1, 15);
        done_cnt = 0;
        exp_v = 8'hFF;
        for (int k = 1; k <= 15; k++) begin
            step();
            if (k == 1) drive(1, 1, MODE_HOLD, 8'h00, 0, 0, 0, 0);
            exp_v = {exp_v[W-2:0], 1'b0};
            if (done === 1'b1) done_cnt++;
            chk($sformatf("m_op%0d", k), exp_v, (k < 15), (k == 15));
        end
        step();
        if (done === 1'b1) done_cnt++;
        chk("m_after", 8'h00, 0, 0);
        total++;
        if (done_cnt != 1) begin
            bad++;
            $display("FAIL m_done_count: saw %0d pulses, required 1", done_cnt);
        end

        // Abort: reset on the second op edge of a ROL x5 burst.
        drive(1, 1, MODE_LOAD, 8'h0F, 0, 0, 0, 0);
        step(); chk("a_load", 8'h0F, 0, 0);
        drive(1, 1, MODE_ROL, 8'h00, 0, 0, 1, 5);
        step(); chk("a_op1", 8'h1E, 1, 0);
        drive(0, 1, MODE_HOLD, 8'h00, 0, 0, 0, 0);
        step(); chk("a_reset", 8'h00, 0, 0);
        rst = 1'b1;
        step(); chk("a_no_done", 8'h00, 0, 0);
        step(); chk("a_no_done2", 8'h00, 0, 0);
        drive(1, 1, MODE_LOAD, 8'h03, 0, 0, 0, 0);
        step(); chk("a_reload", 8'h03, 0, 0);
        drive(1, 1, MODE_ROL, 8'h00, 0, 0, 1, 2);
        step(); chk("a_new_op1", 8'h06, 1, 0);
        drive(1, 1, MODE_HOLD, 8'h00, 0, 0, 0, 0);
        step(); chk("a_new_op2", 8'h0C, 0, 1);
        step(); chk("a_new_after", 8'h0C, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, required normal completion");
        $fatal(1, "timeout");
    end

endmodule
